// File: rtl/bcd_disp_mux_if.sv
// bcd_disp_mux_if: BCD data/load input and multiplexed seven-segment drive outputs
interface bcd_disp_mux_if;
  logic [15:0] bcd_in;
  logic        load;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame;
  modport master (output bcd_in, load, input seg, an, frame);
  modport slave (input bcd_in, load, output seg, an, frame);
endinterface

// File: rtl/bcd_disp_mux.sv
// bcd_disp_mux: four-digit time-multiplexed BCD to seven-segment driver with leading-zero blanking
module bcd_disp_mux #(
  parameter int SCAN_DIV = 4,
  parameter bit BLANK_LZ = 1
) (
  input logic            clk,
  input logic            rst,
  bcd_disp_mux_if.slave  bus
);
  localparam logic [15:0] TC_VAL = 16'(SCAN_DIV - 1);
  logic [15:0] shadow, shadow_nx, pre, pre_nx;
  logic [1:0]  idx, idx_nx;
  logic [3:0]  digit, an_nx;
  logic [6:0]  seg_nx;
  logic        tc, blank, frame_nx;
  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0:    dec = 7'b1000000;
      4'd1:    dec = 7'b1111001;
      4'd2:    dec = 7'b0100100;
      4'd3:    dec = 7'b0110000;
      4'd4:    dec = 7'b0011001;
      4'd5:    dec = 7'b0010010;
      4'd6:    dec = 7'b0000010;
      4'd7:    dec = 7'b1111000;
      4'd8:    dec = 7'b0000000;
      4'd9:    dec = 7'b0010000;
      default: dec = 7'b0111111;
    endcase
  endfunction
  always_comb begin
    tc        = pre == TC_VAL;
    pre_nx    = tc ? 16'd0 : pre + 16'd1;
    idx_nx    = tc ? idx + 2'd1 : idx;
    shadow_nx = bus.load ? bus.bcd_in : shadow;
    digit     = shadow[{idx, 2'b00} +: 4];
    // a digit blanks only when it and every more-significant digit are zero
    blank     = BLANK_LZ && (idx == 2'd1 ? shadow[15:4] == 12'd0 :
                             idx == 2'd2 ? shadow[15:8] == 8'd0 :
                             idx == 2'd3 ? shadow[15:12] == 4'd0 : 1'b0);
    seg_nx    = blank ? 7'b1111111 : dec(digit);
    an_nx     = ~(4'b0001 << idx);
    frame_nx  = idx == 2'd0 && pre == 16'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow    <= '0;
      pre       <= '0;
      idx       <= '0;
      bus.seg   <= 7'b1111111;
      bus.an    <= 4'b1111;
      bus.frame <= 1'b0;
    end else begin
      shadow    <= shadow_nx;
      pre       <= pre_nx;
      idx       <= idx_nx;
      bus.seg   <= seg_nx;
      bus.an    <= an_nx;
      bus.frame <= frame_nx;
    end
  end
endmodule

// File: tb/tb_bcd_disp_mux.sv
// tb_bcd_disp_mux: directed checks of scan order, decode, blanking, load timing and reset
module tb_bcd_disp_mux;
  logic clk, rst;
  int n_tests = 0, n_fail = 0;
  logic [15:0] an_tab = 16'h7BDE;
  bcd_disp_mux_if bus0 ();
  bcd_disp_mux_if bus1 ();
  assign bus1.bcd_in = bus0.bcd_in;
  assign bus1.load   = bus0.load;
  bcd_disp_mux #(.SCAN_DIV(4), .BLANK_LZ(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  bcd_disp_mux #(.SCAN_DIV(4), .BLANK_LZ(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load_val(input logic [15:0] v);
    bus0.bcd_in = v;
    bus0.load = 1;
    step();
    bus0.load = 0;
  endtask
  task automatic wait_frame();
    int k = 0;
    while (bus0.frame !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    check("frame_wait", {15'd0, bus0.frame}, 16'd1);
  endtask
  task automatic scan(input string tag, input logic [27:0] e0, input logic [27:0] e1);
    wait_frame();
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 4; c++) begin
        check({tag, "_an"}, {12'd0, bus0.an}, {12'd0, an_tab[s*4 +: 4]});
        check({tag, "_seg_lz1"}, {9'd0, bus0.seg}, {9'd0, e0[s*7 +: 7]});
        check({tag, "_seg_lz0"}, {9'd0, bus1.seg}, {9'd0, e1[s*7 +: 7]});
        step();
      end
  endtask
  initial begin
    rst = 1;
    bus0.bcd_in = 16'h0;
    bus0.load = 0;
    step();
    check("rst_an", {12'd0, bus0.an}, 16'hF);
    check("rst_seg", {9'd0, bus0.seg}, 16'h7F);
    check("rst_frame", {15'd0, bus0.frame}, 16'd0);
    rst = 0;
    step();
    for (int c = 0; c < 32; c++) begin
      check("idle_an", {12'd0, bus0.an}, {12'd0, an_tab[((c/4)%4)*4 +: 4]});
      check("idle_seg", {9'd0, bus0.seg}, ((c/4)%4) == 0 ? 16'h40 : 16'h7F);
      check("idle_frame", {15'd0, bus0.frame}, (c%16) == 0 ? 16'd1 : 16'd0);
      step();
    end
    load_val(16'h1234);
    scan("d1234", {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001},
                  {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
    load_val(16'h0090);
    scan("d0090", {7'b1111111, 7'b1111111, 7'b0010000, 7'b1000000},
                  {7'b1000000, 7'b1000000, 7'b0010000, 7'b1000000});
    load_val(16'h00A5);
    scan("d00A5", {7'b1111111, 7'b1111111, 7'b0111111, 7'b0010010},
                  {7'b1000000, 7'b1000000, 7'b0111111, 7'b0010010});
    load_val(16'hF000);
    scan("dF000", {7'b0111111, 7'b1000000, 7'b1000000, 7'b1000000},
                  {7'b0111111, 7'b1000000, 7'b1000000, 7'b1000000});
    load_val(16'h0012);
    wait_frame();
    step();
    step();
    bus0.bcd_in = 16'h0087;
    bus0.load = 1;
    step();
    bus0.load = 0;
    check("tc_load_old_d0", {9'd0, bus0.seg}, 16'h24);
    step();
    check("tc_load_d1_an", {12'd0, bus0.an}, 16'hD);
    check("tc_load_d1_seg", {9'd0, bus0.seg}, 16'h00);
    wait_frame();
    check("d0087_d0", {9'd0, bus0.seg}, 16'h78);
    for (int c = 0; c < 9; c++) step();
    check("pre_rst_an", {12'd0, bus0.an}, 16'hB);
    rst = 1;
    step();
    check("midrst_an", {12'd0, bus0.an}, 16'hF);
    check("midrst_seg", {9'd0, bus0.seg}, 16'h7F);
    check("midrst_frame", {15'd0, bus0.frame}, 16'd0);
    rst = 0;
    step();
    check("post_rst_an", {12'd0, bus0.an}, 16'hE);
    check("post_rst_seg", {9'd0, bus0.seg}, 16'h40);
    check("post_rst_frame", {15'd0, bus0.frame}, 16'd1);
    for (int c = 0; c < 4; c++) step();
    check("post_rst_d1_an", {12'd0, bus0.an}, 16'hD);
    check("post_rst_d1_blank", {9'd0, bus0.seg}, 16'h7F);
    check("post_rst_d1_lz0", {9'd0, bus1.seg}, 16'h40);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_disp_mux.md
BCD_DISP_MUX -- requirements
Module: bcd_disp_mux

Interface
REQ-001 Parameter SCAN_DIV, default 4: clock cycles each digit is driven; legal range 2..65535.
REQ-002 Parameter BLANK_LZ, default 1: 1 enables leading-zero blanking, 0 disables it.
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 bcd_in  input  16: four BCD digits from the upstream counter chain; [3:0] is digit 0 (least significant), [15:12] is digit 3.
REQ-006 load  input  1: when high at a rising edge, bcd_in is captured into the shadow register.
REQ-007 seg  output  7: segment drive {g,f,e,d,c,b,a}, active-low, registered.
REQ-008 an  output  4: digit enables, one-hot active-low, registered; an[k] low selects digit k.
REQ-009 frame  output  1: registered one-cycle pulse marking the start of each digit-0 slot.

Function
REQ-010 Shadow register (16 bit): loads bcd_in on an edge with load=1; otherwise holds; display content comes only from the shadow register, never directly from bcd_in.
REQ-011 Prescaler counts 0..SCAN_DIV-1 and wraps to 0; terminal count (TC) is prescaler = SCAN_DIV-1.
REQ-012 Digit index (2 bit): advances 0->1->2->3->0 on each TC edge; otherwise holds.
REQ-013 seg and an are registered from the index value and shadow register present before each edge: one-cycle latency from an index or shadow change to the outputs.
REQ-014 an = ~(4'b0001 << index) on every non-reset edge.
REQ-015 Decode, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-016 Codes 10..15 (invalid BCD) SHALL display a dash: seg=0111111.
REQ-017 Blanking: when BLANK_LZ=1, digit k (k=1..3) is shown as seg=1111111 if shadow digits k..3 are all 0; digit 0 is never blanked; a dash digit is non-zero for this rule.
REQ-018 frame is high for exactly the one cycle in which an first becomes 1110 after index wraps 3->0; it also pulses on the first digit-0 slot after reset.
REQ-019 Simultaneous load and TC: both take effect on the same edge; the following cycle's output reflects the new index with the new shadow data.
REQ-020 load held high: shadow tracks bcd_in every cycle; the scan is unaffected.
REQ-021 A full frame is 4*SCAN_DIV cycles; each digit is driven for exactly SCAN_DIV consecutive cycles.

Reset
REQ-022 rst high at an edge: shadow=0, prescaler=0, index=0, seg=1111111, an=1111, frame=0; rst overrides load and TC.
REQ-023 First edge with rst low: outputs an=1110, seg=1000000 (digit 0 shows "0"), frame=1.
REQ-024 rst asserted mid-frame: the next edge returns every state element to its REQ-022 value; no partial digit slot continues.

Verification
REQ-025 Reset then idle, SCAN_DIV=4 -> an sequence 1110 x4, 1101 x4, 1011 x4, 0111 x4, repeating; seg digit0=1000000; digits 1..3 = 1111111 (blanked); frame every 16 cycles.
REQ-026 load=1 for one cycle with bcd_in=16'h1234 -> digit slots 0..3 show 0011001, 0110000, 0100100, 1111001; no blanking.
REQ-027 bcd_in=16'h0090, BLANK_LZ=1 -> digit0=1000000, digit1=0010000, digits 2,3 = 1111111; with BLANK_LZ=0, digits 2,3 = 1000000.
REQ-028 bcd_in=16'h00A5 -> digit0=0010010, digit1=0111111 (dash), digits 2,3 blank.
REQ-029 load pulsed on the TC edge of digit 0 with bcd_in=16'h0087 (previously 16'h0012) -> digit-1 slot shows 0000000 (8) from its first cycle.
REQ-030 rst pulsed for one cycle during the digit-2 slot -> next cycle an=1111, seg=1111111, shadow 0; the cycle after, an=1110, seg=1000000, frame=1.
